// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NREQ requesters.
// A winner is latched at grant. The arbiter then runs the controller's
// wrreq/rereq handshake. It returns a one-cycle ack, with err set when the
// watchdog aborts the transfer, and read data to the owner.
module sdram_rr_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [ADDR_W-1:0]        sd_addr,
  output logic [DATA_W-1:0]        sd_wdata,
  output logic                     sd_wrreq,
  output logic                     sd_rereq,
  input  logic [DATA_W-1:0]        sd_rdata,
  input  logic                     sd_rwdone,
  input  logic                     sd_rw_wait,
  input  logic                     sd_rw_busy
);

  localparam int OWN_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    rr_q, rr_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0]   sd_wdata_q, sd_wdata_d;
  logic                wrreq_q, wrreq_d;
  logic                rereq_q, rereq_d;
  logic                we_q, we_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic                grant_found;
  logic [OWN_W-1:0]    grant_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                wd_expired;
  logic [NREQ-1:0]     owner_onehot;

  // Pick the first active request at or above the rr pointer, with wrap.
  // The winner's command fields are muxed out at the same time.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_we      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req[i] && ((int'(rr_q) + k) % NREQ) == i) begin
          grant_found = 1'b1;
          grant_idx   = OWN_W'(i);
          sel_we      = we[i];
          sel_addr    = addr[i*ADDR_W +: ADDR_W];
          sel_wdata   = wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign wd_expired   = (wd_q == WD_W'(TIMEOUT - 1));
  assign owner_onehot = NREQ'(1) << owner_q;

  // Next-state and registered-output logic. Completion beats the
  // watchdog, and the watchdog beats the busy acceptance.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    ack_d      = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    wrreq_d    = wrreq_q;
    rereq_d    = rereq_q;
    we_d       = we_q;
    wd_d       = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found && !sd_rw_busy && !sd_rw_wait) begin
          owner_d    = grant_idx;
          sd_addr_d  = sel_addr;
          sd_wdata_d = sel_wdata;
          we_d       = sel_we;
          wrreq_d    = sel_we;
          rereq_d    = !sel_we;
          wd_d       = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT_DONE: begin
        if (sd_rwdone) begin
          wrreq_d = 1'b0;
          rereq_d = 1'b0;
          if (!we_q) rdata_d = sd_rdata;
          ack_d   = owner_onehot;
          state_d = S_RESP;
        end else if (wd_expired) begin
          wrreq_d = 1'b0;
          rereq_d = 1'b0;
          ack_d   = owner_onehot;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
          if (state_q == S_ISSUE && sd_rw_busy) begin
            wrreq_d = 1'b0;
            rereq_d = 1'b0;
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_RESP: begin
        rr_d    = (owner_q == OWN_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      wrreq_q    <= 1'b0;
      rereq_q    <= 1'b0;
      we_q       <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      wrreq_q    <= wrreq_d;
      rereq_q    <= rereq_d;
      we_q       <= we_d;
      wd_q       <= wd_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign owner    = owner_q;
  assign sd_addr  = sd_addr_q;
  assign sd_wdata = sd_wdata_q;
  assign sd_wrreq = wrreq_q;
  assign sd_rereq = rereq_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed testbench for sdram_rr_arbiter with a small behavioural
// SDRAM controller model. The model answers reads with 0xA000 + address.
module tb_sdram_rr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 23;
  localparam int DW   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [DW-1:0]      rdata;
  logic               owner;
  logic [AW-1:0]      sd_addr;
  logic [DW-1:0]      sd_wdata;
  logic               sd_wrreq, sd_rereq;
  logic [DW-1:0]      sd_rdata   = '0;
  logic               sd_rwdone  = 1'b0;
  logic               sd_rw_wait;
  logic               sd_rw_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // controller model knobs
  int m_state = 0;
  int m_cnt   = 0;
  int m_delay = 3;
  bit hang    = 1'b0;

  sdram_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .owner     (owner),
    .sd_addr   (sd_addr),
    .sd_wdata  (sd_wdata),
    .sd_wrreq  (sd_wrreq),
    .sd_rereq  (sd_rereq),
    .sd_rdata  (sd_rdata),
    .sd_rwdone (sd_rwdone),
    .sd_rw_wait(sd_rw_wait),
    .sd_rw_busy(sd_rw_busy)
  );

  always #5 clk = ~clk;

  // Controller model: accepts a request, raises busy, then pulses rwdone
  // m_delay cycles later. Nothing is accepted while hang is set.
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      m_state    = 0;
      sd_rw_busy = 1'b0;
      sd_rwdone  = 1'b0;
    end else begin
      case (m_state)
        0: if ((sd_wrreq || sd_rereq) && !sd_rw_wait && !hang) begin
          sd_rw_busy = 1'b1;
          m_cnt      = 0;
          m_state    = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt >= m_delay) begin
            sd_rwdone = 1'b1;
            sd_rdata  = 16'hA000 + sd_addr[15:0];
            m_state   = 2;
          end
        end
        default: begin
          sd_rwdone  = 1'b0;
          sd_rw_busy = 1'b0;
          m_state    = 0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p]             = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for an ack pulse, sampling 1 time unit after each rising edge.
  // Gives up after 200 cycles and returns ack = 0 in that case.
  task automatic wait_ack(output logic [NREQ-1:0] a, output int cyc);
    a   = '0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] a;
    int              cyc;
    bit              saw;
    logic [AW-1:0]   ctn_addr [2];

    reset = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    sd_rw_wait = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   32'(ack),      32'h0);
    check("rst_err",   32'(err),      32'h0);
    check("rst_rdata", 32'(rdata),    32'h0);
    check("rst_wrreq", 32'(sd_wrreq), 32'h0);
    check("rst_rereq", 32'(sd_rereq), 32'h0);
    check("rst_owner", 32'(owner),    32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single write on port 0
    @(negedge clk);
    set_port(0, 1'b1, 23'h000005, 16'h0005);
    req = 2'b01;
    @(posedge clk);
    #1;
    check("wr_wrreq", 32'(sd_wrreq), 32'h1);
    check("wr_rereq", 32'(sd_rereq), 32'h0);
    check("wr_addr",  32'(sd_addr),  32'h5);
    check("wr_wdata", 32'(sd_wdata), 32'h5);
    check("wr_owner", 32'(owner),    32'h0);
    @(posedge clk);
    #1;
    check("wr_drop_after_busy", 32'(sd_wrreq), 32'h0);
    wait_ack(a, cyc);
    check("wr_ack", 32'(a),   32'h1);
    check("wr_err", 32'(err), 32'h0);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #1;
    check("wr_ack_pulse", 32'(ack), 32'h0);

    // Two readers contend and are served alternately, starting at port 0
    apply_reset();
    ctn_addr[0] = 23'h000010;
    ctn_addr[1] = 23'h000021;
    set_port(0, 1'b0, ctn_addr[0], 16'h0);
    set_port(1, 1'b0, ctn_addr[1], 16'h0);
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_ack(a, cyc);
      check($sformatf("ctn%0d_ack", n),   32'(a),     32'(1 << (n % 2)));
      check($sformatf("ctn%0d_owner", n), 32'(owner), 32'(n % 2));
      check($sformatf("ctn%0d_rdata", n), 32'(rdata), 32'h0000A000 + 32'(ctn_addr[n % 2]));
      check($sformatf("ctn%0d_err", n),   32'(err),   32'h0);
    end
    @(negedge clk);
    req = '0;

    // Controller not ready: no request is issued while wait is high
    repeat (3) @(posedge clk);
    @(negedge clk);
    sd_rw_wait = 1'b1;
    set_port(1, 1'b0, 23'h000005, 16'h0);
    req = 2'b10;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (sd_rereq || sd_wrreq) saw = 1'b1;
    end
    check("wait_no_req", 32'(saw), 32'h0);
    @(negedge clk);
    sd_rw_wait = 1'b0;
    @(posedge clk);
    #1;
    check("wait_rereq", 32'(sd_rereq), 32'h1);
    check("wait_owner", 32'(owner),    32'h1);
    wait_ack(a, cyc);
    check("wait_ack",   32'(a),     32'h2);
    check("wait_rdata", 32'(rdata), 32'h0000A005);
    @(negedge clk);
    req = '0;

    // Watchdog abort when the controller never answers
    repeat (3) @(posedge clk);
    @(negedge clk);
    hang = 1'b1;
    set_port(0, 1'b0, 23'h000033, 16'h0);
    req = 2'b01;
    @(posedge clk);
    #1;
    check("wd_issue", 32'(sd_rereq), 32'h1);
    wait_ack(a, cyc);
    check("wd_cycles", 32'(cyc),      32'd16);
    check("wd_ack",    32'(a),        32'h1);
    check("wd_err",    32'(err),      32'h1);
    check("wd_rdata",  32'(rdata),    32'h0000A005);
    check("wd_rereq",  32'(sd_rereq), 32'h0);
    @(negedge clk);
    req  = '0;
    hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_port(0, 1'b0, 23'h000007, 16'h0);
    req = 2'b01;
    wait_ack(a, cyc);
    check("wd_next_ack",   32'(a),     32'h1);
    check("wd_next_err",   32'(err),   32'h0);
    check("wd_next_rdata", 32'(rdata), 32'h0000A007);
    @(negedge clk);
    req = '0;

    // Reset during WAIT_DONE: no ack, then re-grant from port 0
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_delay = 8;
    set_port(0, 1'b0, 23'h000040, 16'h0);
    set_port(1, 1'b0, 23'h000041, 16'h0);
    req = 2'b11;
    @(posedge clk);
    #1;
    check("rmid_owner_first", 32'(owner), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rmid_ack",   32'(ack),      32'h0);
    check("rmid_rereq", 32'(sd_rereq), 32'h0);
    check("rmid_owner", 32'(owner),    32'h0);
    @(negedge clk);
    reset   = 1'b0;
    m_delay = 3;
    @(posedge clk);
    #1;
    check("rmid_regrant_owner", 32'(owner),    32'h0);
    check("rmid_regrant_rereq", 32'(sd_rereq), 32'h1);
    wait_ack(a, cyc);
    check("rmid_ack0",  32'(a),     32'h1);
    check("rmid_rdata", 32'(rdata), 32'h0000A040);
    @(negedge clk);
    req = '0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
